// File: rtl/fir_1d_5_logic_if.sv
// -----------------------------------------------------------------------------
// fir_1d_5_logic_if
// Pixel-stream bundle of the 5-tap fabric FIR: the sample in (X/X_STRB), the
// tap-line tail (BCOUT) and the result/cascade outputs (Y/PCOUT/Y_STRB).
// The filter is the slave; whoever feeds pixels and consumes results is the
// master.
// -----------------------------------------------------------------------------
interface fir_1d_5_logic_if #(
   parameter int IN_WIDTH  = 12,
   parameter int OUT_WIDTH = 24
) ();

   logic [IN_WIDTH-1:0]  X;
   logic                 X_STRB;
   logic [IN_WIDTH-1:0]  BCOUT;
   logic [OUT_WIDTH-1:0] Y;
   logic [OUT_WIDTH-1:0] PCOUT;
   logic                 Y_STRB;

   modport master (
      output X,
      output X_STRB,
      input  BCOUT,
      input  Y,
      input  PCOUT,
      input  Y_STRB
   );

   modport slave (
      input  X,
      input  X_STRB,
      output BCOUT,
      output Y,
      output PCOUT,
      output Y_STRB
   );

endinterface

// File: rtl/fir_1d_5_logic.sv
// -----------------------------------------------------------------------------
// fir_1d_5_logic
// 5-tap 1D FIR for 12-bit unsigned pixels with signed Q4.8 coefficients,
// built from plain fabric logic. An addend (external C or cascade PCIN) is
// folded into the last stage so one instance per image line can be chained
// into a 5x5 2D filter.
//
// Pipeline (all registers advance only on CE, RST wins over CE):
//   stage 1  tap line x0..x4 (shifts only on X_STRB)
//   stage 2  five registered products
//   stage 3  two registered partial sums (p0+p1+p2, p3+p4)
//   stage 4  final sum + addend -> Y / PCOUT
//
// Build option:
//   FIR_1D_SAT_EN  defined   : sums carried wider, Y clamps to the signed
//                              OUT_WIDTH range on overflow
//                  undefined : Y wraps modulo 2^OUT_WIDTH
// -----------------------------------------------------------------------------
module fir_1d_5_logic #(
   parameter int IN_WIDTH  = 12,
   parameter int OUT_WIDTH = 24
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 CE,
   input  logic [IN_WIDTH-1:0]  H0,
   input  logic [IN_WIDTH-1:0]  H1,
   input  logic [IN_WIDTH-1:0]  H2,
   input  logic [IN_WIDTH-1:0]  H3,
   input  logic [IN_WIDTH-1:0]  H4,
   input  logic [47:0]          C,
   input  logic [47:0]          PCIN,
   input  logic [7:0]           OPMODE,
   fir_1d_5_logic_if.slave      strm
);

   // Accumulation width: the wrap build keeps exactly OUT_WIDTH bits; the
   // saturating build carries enough headroom for five products plus the
   // addend so the overflow decision sees the true sum.
`ifdef FIR_1D_SAT_EN
   localparam int ACC_W = OUT_WIDTH + 3;
`else
   localparam int ACC_W = OUT_WIDTH;
`endif

   // Signed coefficient times unsigned pixel. The pixel gets a zero MSB so it
   // stays positive; the full product is kept to OUT_WIDTH bits.
   function automatic logic signed [OUT_WIDTH-1:0] tap_product(
      input logic [IN_WIDTH-1:0] h,
      input logic [IN_WIDTH-1:0] x
   );
      logic signed [IN_WIDTH:0]     h_ext;
      logic signed [IN_WIDTH:0]     x_ext;
      logic signed [2*IN_WIDTH+1:0] full;
      h_ext = {h[IN_WIDTH-1], h};
      x_ext = {1'b0, x};
      full  = h_ext * x_ext;
      return OUT_WIDTH'(full);
   endfunction

   // Upper bits of the wide addend buses and OPMODE[7:4] carry no meaning here.
   logic unused_bits_s;
   assign unused_bits_s = &{1'b0, OPMODE[7:4], C[47:OUT_WIDTH], PCIN[47:OUT_WIDTH]};

   // Pipeline state
   logic [IN_WIDTH-1:0]         x_r [5];
   logic signed [OUT_WIDTH-1:0] p_r [5];
   logic signed [ACC_W-1:0]     psa_r;
   logic signed [ACC_W-1:0]     psb_r;
   logic [OUT_WIDTH-1:0]        y_r;
   logic [3:0]                  strb_r;

   // Combinational helpers
   logic signed [ACC_W-1:0]     sum_a_s;
   logic signed [ACC_W-1:0]     sum_b_s;
   logic signed [ACC_W-1:0]     prod_term_s;
   logic signed [ACC_W-1:0]     addend_s;
   logic signed [ACC_W-1:0]     total_s;
   logic [OUT_WIDTH-1:0]        y_next_s;

   // Stage 1: tap line, advances only when a valid sample is offered.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int k = 0; k < 5; k++) begin
            x_r[k] <= {IN_WIDTH{1'b0}};
         end
      end else if (CE && strm.X_STRB) begin
         x_r[0] <= strm.X;
         for (int k = 1; k < 5; k++) begin
            x_r[k] <= x_r[k-1];
         end
      end
   end

   // Stage 2: one registered product per tap.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int k = 0; k < 5; k++) begin
            p_r[k] <= {OUT_WIDTH{1'b0}};
         end
      end else if (CE) begin
         p_r[0] <= tap_product(H0, x_r[0]);
         p_r[1] <= tap_product(H1, x_r[1]);
         p_r[2] <= tap_product(H2, x_r[2]);
         p_r[3] <= tap_product(H3, x_r[3]);
         p_r[4] <= tap_product(H4, x_r[4]);
      end
   end

   // Partial sums feeding stage 3; products are sign-extended to ACC_W.
   always_comb begin
      sum_a_s = ACC_W'(p_r[0]) + ACC_W'(p_r[1]) + ACC_W'(p_r[2]);
      sum_b_s = ACC_W'(p_r[3]) + ACC_W'(p_r[4]);
   end

   // Stage 3: two registered partial sums.
   always_ff @(posedge CLK) begin
      if (RST) begin
         psa_r <= {ACC_W{1'b0}};
         psb_r <= {ACC_W{1'b0}};
      end else if (CE) begin
         psa_r <= sum_a_s;
         psb_r <= sum_b_s;
      end
   end

   // OPMODE[1:0]: product term enable (only 00 suppresses it).
   always_comb begin
      prod_term_s = {ACC_W{1'b0}};
      case (OPMODE[1:0])
         2'b00:               prod_term_s = {ACC_W{1'b0}};
         2'b01, 2'b10, 2'b11: prod_term_s = psa_r + psb_r;
         default:             prod_term_s = {ACC_W{1'b0}};
      endcase
   end

   // OPMODE[3:2]: addend select; only the low OUT_WIDTH bits are used, signed.
   always_comb begin
      addend_s = {ACC_W{1'b0}};
      case (OPMODE[3:2])
         2'b00:   addend_s = {ACC_W{1'b0}};
         2'b01:   addend_s = ACC_W'(signed'(PCIN[OUT_WIDTH-1:0]));
         2'b10:   addend_s = {ACC_W{1'b0}};
         2'b11:   addend_s = ACC_W'(signed'(C[OUT_WIDTH-1:0]));
         default: addend_s = {ACC_W{1'b0}};
      endcase
   end

   assign total_s = prod_term_s + addend_s;

   // Stage-4 result: wrap, or clamp to the signed OUT_WIDTH range when built in.
   always_comb begin
      y_next_s = total_s[OUT_WIDTH-1:0];
`ifdef FIR_1D_SAT_EN
      if (total_s[ACC_W-1:OUT_WIDTH-1] == {(ACC_W-OUT_WIDTH+1){total_s[ACC_W-1]}}) begin
         y_next_s = total_s[OUT_WIDTH-1:0];
      end else if (total_s[ACC_W-1]) begin
         y_next_s = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      end else begin
         y_next_s = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
`endif
   end

   // Stage 4: result register; the addend is sampled here, so it reaches Y
   // one CE-cycle after it changes.
   always_ff @(posedge CLK) begin
      if (RST) begin
         y_r <= {OUT_WIDTH{1'b0}};
      end else if (CE) begin
         y_r <= y_next_s;
      end
   end

   // Strobe pipeline: X_STRB delayed by the four pipeline stages.
   always_ff @(posedge CLK) begin
      if (RST) begin
         strb_r <= 4'b0000;
      end else if (CE) begin
         strb_r <= {strb_r[2:0], strm.X_STRB};
      end
   end

   assign strm.BCOUT  = x_r[4];
   assign strm.Y      = y_r;
   assign strm.PCOUT  = y_r;
   assign strm.Y_STRB = strb_r[3];

endmodule

// File: tb/tb_fir_1d_5_logic.sv
// -----------------------------------------------------------------------------
// tb_fir_1d_5_logic
// Directed bench for fir_1d_5_logic: impulse responses, tap order, negative
// coefficients, addend selection, CE freeze, X_STRB gaps and mid-stream reset.
// Expected values are hand-computed from the filter equation.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fir_1d_5_logic;

   logic        CLK;
   logic        RST;
   logic        CE;
   logic [11:0] H0, H1, H2, H3, H4;
   logic [47:0] C;
   logic [47:0] PCIN;
   logic [7:0]  OPMODE;

   int n_checks;
   int n_errors;

   fir_1d_5_logic_if #(.IN_WIDTH(12), .OUT_WIDTH(24)) strm_if ();

   fir_1d_5_logic #(.IN_WIDTH(12), .OUT_WIDTH(24)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .CE     (CE),
      .H0     (H0),
      .H1     (H1),
      .H2     (H2),
      .H3     (H3),
      .H4     (H4),
      .C      (C),
      .PCIN   (PCIN),
      .OPMODE (OPMODE),
      .strm   (strm_if)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Count a comparison and report it when observed and expected differ.
   task automatic check_value(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock edge; outputs are then stable 1 ns after it.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_coeffs(input logic [11:0] a, b, c, d, e);
      H0 = a; H1 = b; H2 = c; H3 = d; H4 = e;
   endtask

   // Expected Y for an X=0x001 impulse with H=0x100..0x500, t edges after it.
   function automatic logic [47:0] tap_exp(input int t);
      if (t >= 3 && t <= 7) return 48'(t - 2) * 48'h100;
      return 48'h0;
   endfunction

   initial begin
      n_checks = 0;
      n_errors = 0;
      RST = 1'b1; CE = 1'b1;
      set_coeffs(12'h100, 12'h100, 12'h100, 12'h100, 12'h100);
      C = 48'h0; PCIN = 48'h0; OPMODE = 8'h05;
      strm_if.X = 12'h000; strm_if.X_STRB = 1'b1;

      // ---- reset state ----
      tick();
      RST = 1'b0;
      check_value("rst_y",      48'(strm_if.Y),      48'h0);
      check_value("rst_pcout",  48'(strm_if.PCOUT),  48'h0);
      check_value("rst_bcout",  48'(strm_if.BCOUT),  48'h0);
      check_value("rst_ystrb",  48'(strm_if.Y_STRB), 48'h0);

      // ---- impulse, unity coefficients ----
      repeat (6) tick();
      check_value("imp_ystrb_on", 48'(strm_if.Y_STRB), 48'h1);
      strm_if.X = 12'hFFF;
      tick();
      strm_if.X = 12'h000;
      for (int t = 1; t <= 9; t++) begin
         tick();
         check_value($sformatf("imp_y_t%0d", t), 48'(strm_if.Y),
                     (t >= 3 && t <= 7) ? 48'h0FFF00 : 48'h0);
         check_value($sformatf("imp_pcout_t%0d", t), 48'(strm_if.PCOUT),
                     (t >= 3 && t <= 7) ? 48'h0FFF00 : 48'h0);
         check_value($sformatf("imp_bcout_t%0d", t), 48'(strm_if.BCOUT),
                     (t == 4) ? 48'hFFF : 48'h0);
      end

      // ---- tap order ----
      set_coeffs(12'h100, 12'h200, 12'h300, 12'h400, 12'h500);
      repeat (6) tick();
      strm_if.X = 12'h001;
      tick();
      strm_if.X = 12'h000;
      for (int t = 1; t <= 9; t++) begin
         tick();
         check_value($sformatf("tap_y_t%0d", t), 48'(strm_if.Y), tap_exp(t));
      end

      // ---- CE freeze mid-impulse ----
      strm_if.X = 12'h001;
      tick();
      strm_if.X = 12'h000;
      for (int t = 1; t <= 4; t++) tick();
      check_value("ce_pre_y", 48'(strm_if.Y), 48'h000200);
      CE = 1'b0;
      strm_if.X = 12'h555;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_value($sformatf("ce_hold_y_%0d", k),     48'(strm_if.Y),      48'h000200);
         check_value($sformatf("ce_hold_bcout_%0d", k), 48'(strm_if.BCOUT),  48'h001);
         check_value($sformatf("ce_hold_ystrb_%0d", k), 48'(strm_if.Y_STRB), 48'h1);
      end
      CE = 1'b1;
      strm_if.X = 12'h000;
      for (int t = 5; t <= 9; t++) begin
         tick();
         check_value($sformatf("ce_resume_y_t%0d", t), 48'(strm_if.Y), tap_exp(t));
      end

      // ---- X_STRB gaps: no shift while low, Y keeps updating ----
      strm_if.X = 12'h001;
      tick();
      strm_if.X = 12'hAAA; strm_if.X_STRB = 1'b0;
      tick();
      tick();
      strm_if.X = 12'h000; strm_if.X_STRB = 1'b1;
      for (int e = 3; e <= 10; e++) begin
         tick();
         check_value($sformatf("strb_y_e%0d", e), 48'(strm_if.Y),
                     (e <= 5) ? 48'h000100 : tap_exp(e - 2));
         if (e == 4) check_value("strb_ystrb_e4", 48'(strm_if.Y_STRB), 48'h0);
         if (e == 6) check_value("strb_ystrb_e6", 48'(strm_if.Y_STRB), 48'h1);
      end

      // ---- mid-stream reset (with CE low: reset wins) ----
      strm_if.X = 12'h001;
      tick();
      strm_if.X = 12'h000;
      for (int t = 1; t <= 4; t++) tick();
      check_value("rst_mid_pre_y", 48'(strm_if.Y), 48'h000200);
      RST = 1'b1; CE = 1'b0;
      tick();
      RST = 1'b0; CE = 1'b1;
      check_value("rst_mid_y",     48'(strm_if.Y),      48'h0);
      check_value("rst_mid_pcout", 48'(strm_if.PCOUT),  48'h0);
      check_value("rst_mid_bcout", 48'(strm_if.BCOUT),  48'h0);
      check_value("rst_mid_ystrb", 48'(strm_if.Y_STRB), 48'h0);
      for (int t = 0; t < 6; t++) begin
         tick();
         check_value($sformatf("rst_mid_after_%0d", t), 48'(strm_if.Y), 48'h0);
      end

      // ---- negative coefficient ----
      set_coeffs(12'hF00, 12'h000, 12'h000, 12'h000, 12'h000);
      strm_if.X = 12'h800;
      repeat (6) tick();
      check_value("neg_y", 48'(strm_if.Y), 48'hF80000);

      // ---- addend / product select ----
      OPMODE = 8'h0C; C = 48'hABCD_EF00_0123;
      repeat (2) tick();
      check_value("opm_0c_y", 48'(strm_if.Y), 48'h000123);
      OPMODE = 8'h0E;
      tick();
      check_value("opm_0e_y", 48'(strm_if.Y), 48'hF80123);
      strm_if.X = 12'h000;
      OPMODE = 8'h05;
      repeat (6) tick();
      check_value("x0_flush_y", 48'(strm_if.Y), 48'h0);
      OPMODE = 8'h0D;
      tick();
      check_value("opm_0d_c", 48'(strm_if.Y), 48'h000123);
      OPMODE = 8'h05; PCIN = 48'hFFFF_FF00_0456;
      tick();
      check_value("opm_05_pcin", 48'(strm_if.Y), 48'h000456);
      OPMODE = 8'h01;
      tick();
      check_value("opm_01_zero", 48'(strm_if.Y), 48'h0);
      OPMODE = 8'h09;
      tick();
      check_value("opm_09_zero", 48'(strm_if.Y), 48'h0);
      OPMODE = 8'hFD;
      tick();
      check_value("opm_fd_c", 48'(strm_if.Y), 48'h000123);
      C = 48'h0000_0000_FFFF;
      tick();
      check_value("opm_fd_c2", 48'(strm_if.Y), 48'h00FFFF);

`ifdef FIR_1D_SAT_EN
      // ---- positive clamp ----
      OPMODE = 8'h01;
      set_coeffs(12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF);
      strm_if.X = 12'hFFF;
      repeat (8) tick();
      check_value("sat_pos_y", 48'(strm_if.Y), 48'h7FFFFF);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
